// File: rtl/spectrum_frame_buffer_pkg.sv
// Shared definitions for the spectrum frame buffer: write-side FSM encoding and
// default geometry constants.
package spectrum_frame_buffer_pkg;

   localparam int unsigned SFB_DATA_WIDTH = 24;
   localparam int unsigned SFB_N_BINS     = 512;

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      FILL      = 1'b1
   } sfb_wr_state_e;

endpackage

// File: rtl/spectrum_frame_buffer_if.sv
// Bundle of the magnitude stream, read port and status signals of the frame
// buffer; master is the producer/reader side, slave is the buffer.
interface spectrum_frame_buffer_if
   import spectrum_frame_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SFB_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = 9
);
   logic [DATA_WIDTH-1:0] i_magnitude;
   logic                  i_valid;
   logic                  i_frame_start;
   logic                  i_rd_en;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic                  i_frame_done;
   logic [DATA_WIDTH-1:0] o_rd_data;
   logic                  o_rd_valid;
   logic                  o_frame_ready;
   logic [ADDR_WIDTH-1:0] o_peak_bin;
   logic [DATA_WIDTH-1:0] o_peak_mag;
   logic                  o_overrun;
   logic                  o_sync_error;

   modport master (
      output i_magnitude, i_valid, i_frame_start, i_rd_en, i_rd_addr, i_frame_done,
      input  o_rd_data, o_rd_valid, o_frame_ready, o_peak_bin, o_peak_mag,
             o_overrun, o_sync_error
   );

   modport slave (
      input  i_magnitude, i_valid, i_frame_start, i_rd_en, i_rd_addr, i_frame_done,
      output o_rd_data, o_rd_valid, o_frame_ready, o_peak_bin, o_peak_mag,
             o_overrun, o_sync_error
   );
endinterface

// File: rtl/spectrum_frame_buffer_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the address MSB selects
// the bank. One write port and one registered read port.
module sfb_dual_port_ram #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned AW         = 10,
   parameter int unsigned DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [AW-1:0]         i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         rdata_q <= mem_q[i_raddr];
      end
   end

   assign o_rdata = rdata_q;
endmodule

// File: rtl/spectrum_frame_buffer.sv
// Ping-pong spectrum frame buffer: fills one bank from the magnitude stream while
// the reader accesses the other, tracking the peak bin of each frame.
module spectrum_frame_buffer
   import spectrum_frame_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SFB_DATA_WIDTH,
   parameter int unsigned N_BINS     = SFB_N_BINS,
   parameter int unsigned ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] i_magnitude,
   input  logic                  i_valid,
   input  logic                  i_frame_start,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   input  logic                  i_frame_done,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid,
   output logic                  o_frame_ready,
   output logic [ADDR_WIDTH-1:0] o_peak_bin,
   output logic [DATA_WIDTH-1:0] o_peak_mag,
   output logic                  o_overrun,
   output logic                  o_sync_error
);
   localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(N_BINS - 1);

   sfb_wr_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  bank_q, bank_d;
   logic                  ready_q, ready_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overrun_q, overrun_d;
   logic                  sync_err_q, sync_err_d;
   logic [ADDR_WIDTH-1:0] run_bin_q, run_bin_d;
   logic [DATA_WIDTH-1:0] run_mag_q, run_mag_d;
   logic [ADDR_WIDTH-1:0] peak_bin_q, peak_bin_d;
   logic [DATA_WIDTH-1:0] peak_mag_q, peak_mag_d;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_bin;
   logic                  frame_complete;
   logic                  release_ok;
   logic                  rd_en_ok;
   logic [DATA_WIDTH-1:0] ram_rdata;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      bank_d         = bank_q;
      ready_d        = ready_q;
      overrun_d      = 1'b0;
      sync_err_d     = 1'b0;
      run_bin_d      = run_bin_q;
      run_mag_d      = run_mag_q;
      peak_bin_d     = peak_bin_q;
      peak_mag_d     = peak_mag_q;
      wr_en          = 1'b0;
      wr_bin         = idx_q;
      frame_complete = 1'b0;
      release_ok     = i_frame_done && ready_q;
      rd_en_ok       = i_rd_en && ready_q;
      rd_valid_d     = rd_en_ok;

      // A start-qualified sample always restarts the frame at bin 0, even mid-fill.
      if (i_valid) begin
         if (i_frame_start) begin
            wr_en      = 1'b1;
            wr_bin     = '0;
            sync_err_d = (state_q == FILL);
            run_bin_d  = '0;
            run_mag_d  = i_magnitude;
         end else if (state_q == FILL) begin
            wr_en = 1'b1;
            if (i_magnitude > run_mag_q) begin
               run_bin_d = idx_q;
               run_mag_d = i_magnitude;
            end
         end
      end

      if (wr_en) begin
         if (wr_bin == LAST_BIN) begin
            frame_complete = 1'b1;
            state_d        = WAIT_SYNC;
            idx_d          = '0;
         end else begin
            state_d = FILL;
            idx_d   = wr_bin + ADDR_WIDTH'(1);
         end
      end

      // A release landing on the completion cycle frees the read bank in time to swap.
      if (frame_complete) begin
         if (!ready_q || release_ok) begin
            bank_d     = ~bank_q;
            ready_d    = 1'b1;
            peak_bin_d = run_bin_d;
            peak_mag_d = run_mag_d;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (release_ok) begin
         ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_SYNC;
         idx_q      <= '0;
         bank_q     <= 1'b0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         sync_err_q <= 1'b0;
         run_bin_q  <= '0;
         run_mag_q  <= '0;
         peak_bin_q <= '0;
         peak_mag_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         bank_q     <= bank_d;
         ready_q    <= ready_d;
         rd_valid_q <= rd_valid_d;
         overrun_q  <= overrun_d;
         sync_err_q <= sync_err_d;
         run_bin_q  <= run_bin_d;
         run_mag_q  <= run_mag_d;
         peak_bin_q <= peak_bin_d;
         peak_mag_q <= peak_mag_d;
      end
   end

   sfb_dual_port_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (ADDR_WIDTH + 1),
      .DEPTH      (2 * N_BINS)
   ) u_ram (
      .clk     (clk),
      .i_we    (wr_en && !reset),
      .i_waddr ({bank_q, wr_bin}),
      .i_wdata (i_magnitude),
      .i_re    (rd_en_ok && !reset),
      .i_raddr ({~bank_q, i_rd_addr}),
      .o_rdata (ram_rdata)
   );

   // The RAM read register has no reset, so data is masked until a read lands.
   assign o_rd_data     = rd_valid_q ? ram_rdata : '0;
   assign o_rd_valid    = rd_valid_q;
   assign o_frame_ready = ready_q;
   assign o_peak_bin    = peak_bin_q;
   assign o_peak_mag    = peak_mag_q;
   assign o_overrun     = overrun_q;
   assign o_sync_error  = sync_err_q;
endmodule
